scan_mux: RTL and testbench



---
 rtl/scan_mux.sv | 134 +++++++++++++
 tb/tb_scan_mux.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// scan_mux: N-channel, W-bit registered multiplexer with active-low enable.
// Manual mode presents the externally selected channel; auto-scan mode steps
// an internal pointer through every channel, holding each for DWELL cycles.
module scan_mux #(
  parameter  int unsigned NCH   = 32,
  parameter  int unsigned W     = 8,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned SEL_W = $clog2(NCH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NCH*W-1:0]   D,
  input  logic [SEL_W-1:0]   S,
  input  logic               EN,
  input  logic               MODE,
  input  logic               HOLD,
  output logic [W-1:0]       Y,
  output logic [SEL_W-1:0]   CH,
  output logic               VALID,
  output logic               WRAP
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0]   NCH_EXT  = (SEL_W+1)'(NCH);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NCH - 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, cur_ptr;
  logic [DW_W-1:0]  dwell, dwell_nxt, cur_dwell;
  logic [W-1:0]     y_nxt, man_data, scan_data;
  logic [SEL_W-1:0] ch_nxt;
  logic             valid_nxt, wrap_nxt, s_in_range;

  // Scan always starts from channel 0 when entered from another state
  assign cur_ptr    = (state == SCAN) ? ptr   : '0;
  assign cur_dwell  = (state == SCAN) ? dwell : '0;
  assign s_in_range = ({1'b0, S} < NCH_EXT);

  // Channel data selected by the manual select (zero when out of range)
  always_comb begin
    man_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (S == SEL_W'(k)) man_data = D[k*W +: W];
    end
  end

  // Live channel data at the scan pointer
  always_comb begin
    scan_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (cur_ptr == SEL_W'(k)) scan_data = D[k*W +: W];
    end
  end

  // Next state and next registered outputs from sampled EN/MODE/HOLD
  always_comb begin
    state_nxt = IDLE;
    ptr_nxt   = ptr;
    dwell_nxt = dwell;
    y_nxt     = '0;
    ch_nxt    = CH;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;

    if (EN)        state_nxt = IDLE;
    else if (MODE) state_nxt = SCAN;
    else           state_nxt = MAN;

    case (state_nxt)
      IDLE: begin
        ptr_nxt   = '0;
        dwell_nxt = '0;
      end
      MAN: begin
        ptr_nxt   = '0;
        dwell_nxt = '0;
        ch_nxt    = S;
        if (s_in_range) begin
          y_nxt     = man_data;
          valid_nxt = 1'b1;
        end
      end
      SCAN: begin
        y_nxt     = scan_data;
        ch_nxt    = cur_ptr;
        valid_nxt = 1'b1;
        ptr_nxt   = cur_ptr;
        dwell_nxt = cur_dwell;
        if (!HOLD) begin
          if (cur_dwell == DW_LAST) begin
            dwell_nxt = '0;
            ptr_nxt   = (cur_ptr == PTR_LAST) ? '0 : SEL_W'(cur_ptr + 1'b1);
            wrap_nxt  = (cur_ptr == PTR_LAST);
          end else begin
            dwell_nxt = DW_W'(cur_dwell + 1'b1);
          end
        end
      end
      default: begin
        ptr_nxt   = '0;
        dwell_nxt = '0;
      end
    endcase
  end

  // State, counters and output registers; reset clears everything at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      dwell <= '0;
      Y     <= '0;
      CH    <= '0;
      VALID <= 1'b0;
      WRAP  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      dwell <= dwell_nxt;
      Y     <= y_nxt;
      CH    <= ch_nxt;
      VALID <= valid_nxt;
      WRAP  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed testbench for scan_mux: a 32x8/DWELL=4 instance and a 6x4/DWELL=1 instance.
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst;

  logic [32*8-1:0] d_a;
  logic [4:0]      s_a;
  logic            en_a, mode_a, hold_a;
  logic [7:0]      y_a;
  logic [4:0]      ch_a;
  logic            valid_a, wrap_a;

  logic [6*4-1:0]  d_b;
  logic [2:0]      s_b;
  logic            en_b, mode_b, hold_b;
  logic [3:0]      y_b;
  logic [2:0]      ch_b;
  logic            valid_b, wrap_b;

  int n_cmp = 0;
  int n_err = 0;

  scan_mux #(.NCH(32), .W(8), .DWELL(4)) dut_a (
    .CLK(clk), .RST(rst), .D(d_a), .S(s_a), .EN(en_a), .MODE(mode_a),
    .HOLD(hold_a), .Y(y_a), .CH(ch_a), .VALID(valid_a), .WRAP(wrap_a)
  );

  scan_mux #(.NCH(6), .W(4), .DWELL(1)) dut_b (
    .CLK(clk), .RST(rst), .D(d_b), .S(s_b), .EN(en_b), .MODE(mode_b),
    .HOLD(hold_b), .Y(y_b), .CH(ch_b), .VALID(valid_b), .WRAP(wrap_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] y, input logic [4:0] ch,
                       input logic v, input logic w);
    chk({tag, ".Y"}, 32'(y_a), 32'(y));
    chk({tag, ".CH"}, 32'(ch_a), 32'(ch));
    chk({tag, ".VALID"}, 32'(valid_a), 32'(v));
    chk({tag, ".WRAP"}, 32'(wrap_a), 32'(w));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] y, input logic [2:0] ch,
                       input logic v, input logic w);
    chk({tag, ".Y"}, 32'(y_b), 32'(y));
    chk({tag, ".CH"}, 32'(ch_b), 32'(ch));
    chk({tag, ".VALID"}, 32'(valid_b), 32'(v));
    chk({tag, ".WRAP"}, 32'(wrap_b), 32'(w));
  endtask

  initial begin
    int ch;

    // Reset with all-ones data and enabled inputs
    rst = 1'b1;
    d_a = '1; s_a = '0; en_a = 1'b0; mode_a = 1'b0; hold_a = 1'b0;
    d_b = '0; s_b = '0; en_b = 1'b1; mode_b = 1'b0; hold_b = 1'b0;
    tick();
    tick();
    chk_a("reset", 8'h00, 5'd0, 1'b0, 1'b0);

    // Release reset while disabled
    en_a = 1'b1;
    rst  = 1'b0;
    tick();
    tick();
    chk_a("disabled", 8'h00, 5'd0, 1'b0, 1'b0);

    // Manual sweep with D[k] = k + 0x10
    for (int k = 0; k < 32; k++) d_a[k*8 +: 8] = 8'(k + 16);
    en_a = 1'b0;
    for (int s = 0; s < 32; s++) begin
      s_a = 5'(s);
      tick();
      chk_a($sformatf("man_s%0d", s), 8'(s + 16), 5'(s), 1'b1, 1'b0);
    end

    // Disable dominates mode and hold; CH holds last value
    en_a = 1'b1; mode_a = 1'b1; hold_a = 1'b1;
    tick();
    chk_a("en_off", 8'h00, 5'd31, 1'b0, 1'b0);
    hold_a = 1'b0;

    // Full scan: 4 cycles per channel, wrap on output cycle 128, 129th is channel 0
    en_a = 1'b0;
    for (int i = 0; i < 129; i++) begin
      tick();
      ch = (i / 4) % 32;
      chk_a($sformatf("scan_i%0d", i), 8'(ch + 16), 5'(ch), 1'b1, (i == 127));
    end

    // Restart scan and stop on the second cycle of channel 5
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    for (int j = 0; j < 22; j++) tick();
    chk_a("pre_hold", 8'h15, 5'd5, 1'b1, 1'b0);

    // Hold for 10 cycles while channel 5 data changes
    hold_a = 1'b1;
    for (int h = 0; h < 10; h++) begin
      tick();
      chk_a($sformatf("hold_h%0d", h), (h >= 3) ? 8'hAA : 8'h15, 5'd5, 1'b1, 1'b0);
      if (h == 2) d_a[5*8 +: 8] = 8'hAA;
    end

    // Remaining two dwell cycles of channel 5, then channel 6
    hold_a = 1'b0;
    tick();
    chk_a("unhold0", 8'hAA, 5'd5, 1'b1, 1'b0);
    tick();
    chk_a("unhold1", 8'hAA, 5'd5, 1'b1, 1'b0);
    tick();
    chk_a("unhold2", 8'h16, 5'd6, 1'b1, 1'b0);
    d_a[5*8 +: 8] = 8'h15;

    // Asynchronous reset mid-scan clears outputs without a clock edge
    tick();
    rst = 1'b1;
    #2;
    chk_a("async_rst", 8'h00, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // Scan to channel 9 third dwell cycle, then switch to manual S=3
    for (int j = 0; j < 39; j++) tick();
    chk_a("pre_switch", 8'h19, 5'd9, 1'b1, 1'b0);
    mode_a = 1'b0; s_a = 5'd3;
    tick();
    chk_a("to_man", 8'h13, 5'd3, 1'b1, 1'b0);

    // Back to scan: channel 0 for a full dwell, then channel 1
    mode_a = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_a($sformatf("rescan%0d", j), 8'h10, 5'd0, 1'b1, 1'b0);
    end
    tick();
    chk_a("rescan4", 8'h11, 5'd1, 1'b1, 1'b0);

    // Six-channel, 4-bit instance with D[k] = k + 1
    en_a = 1'b1;
    for (int k = 0; k < 6; k++) d_b[k*4 +: 4] = 4'(k + 1);
    en_b = 1'b0; mode_b = 1'b0; s_b = 3'd6;
    tick();
    chk_b("b_man_s6", 4'h0, 3'd6, 1'b0, 1'b0);
    s_b = 3'd7;
    tick();
    chk_b("b_man_s7", 4'h0, 3'd7, 1'b0, 1'b0);
    s_b = 3'd2;
    tick();
    chk_b("b_man_s2", 4'h3, 3'd2, 1'b1, 1'b0);

    // DWELL=1 scan: 0,1,2,3,4,5,0 with wrap on channel 5
    mode_b = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      ch = j % 6;
      chk_b($sformatf("b_scan%0d", j), 4'(ch + 1), 3'(ch), 1'b1, (j == 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
